prml_viterbi_dicode: RTL and testbench

//  Parametrised soft-decision Viterbi detector for the 1-D (dicode) PRML read channel.

---
 rtl/prml_viterbi_dicode_if.sv | 22 ++
 rtl/prml_viterbi_dicode.sv | 142 ++++++++++++++
 tb/tb_prml_viterbi_dicode.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/prml_viterbi_dicode_if.sv
// Sample-in / decision-out bundle for the dicode Viterbi detector.
interface prml_viterbi_dicode_if #(
    parameter int SAMPLE_W = 8,
    parameter int CNT_W    = 16
);
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_sample;
    logic                       out_valid;
    logic                       out_bit;
    logic                       err;
    logic [CNT_W-1:0]           err_count;

    modport master (
        output in_valid, in_sample,
        input  out_valid, out_bit, err, err_count
    );

    modport slave (
        input  in_valid, in_sample,
        output out_valid, out_bit, err, err_count
    );
endinterface

// File: rtl/prml_viterbi_dicode.sv
// Two-state soft-decision Viterbi detector for a 1-D (dicode) PRML channel,
// register-exchange survivors and a saturating count of off-trellis samples.

// Add-compare-select for one destination state; ties go to predecessor 0.
module prml_viterbi_acs #(
    parameter int PM_W = 10
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [PM_W-1:0] bm_a,
    input  logic [PM_W-1:0] bm_b,
    output logic [PM_W-1:0] pm_new,
    output logic            sel
);
    localparam logic [PM_W:0] MAX = {1'b0, {PM_W{1'b1}}};

    logic [PM_W:0]   sum_a, sum_b;
    logic [PM_W-1:0] cand_a, cand_b;

    always_comb begin
        sum_a  = {1'b0, pm_a} + {1'b0, bm_a};
        sum_b  = {1'b0, pm_b} + {1'b0, bm_b};
        cand_a = (sum_a > MAX) ? '1 : sum_a[PM_W-1:0];
        cand_b = (sum_b > MAX) ? '1 : sum_b[PM_W-1:0];
        sel    = (cand_b < cand_a);
        pm_new = sel ? cand_b : cand_a;
    end
endmodule

module prml_viterbi_dicode #(
    parameter int SAMPLE_W   = 8,
    parameter int AMP        = 32,
    parameter int PM_W       = 10,
    parameter int TB_DEPTH   = 16,
    parameter int ERR_THRESH = 24,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    prml_viterbi_dicode_if.slave bus
);
    localparam int BW     = SAMPLE_W + 2;
    localparam int FW     = $clog2(TB_DEPTH);
    localparam int PM_MAX = (1 << PM_W) - 1;
    localparam logic signed [BW-1:0] AMP_S    = BW'(AMP);
    localparam logic        [FW-1:0] FILL_MAX = FW'(TB_DEPTH - 1);

    function automatic logic [BW-1:0] mag(input logic signed [BW-1:0] x);
        return x[BW-1] ? -x : x;
    endfunction

    function automatic logic [PM_W-1:0] sat_bm(input logic [BW-1:0] a);
        if (32'(a) > 32'(PM_MAX)) return '1;
        return PM_W'(a);
    endfunction

    logic [1:0][PM_W-1:0]     pm_q, pm_d, pm_acs;
    logic [1:0][TB_DEPTH-1:0] surv_q, surv_d;
    logic [1:0]               sel;
    logic [FW-1:0]            fill_q, fill_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_bit_q, out_bit_d;
    logic                     err_q, err_d;
    logic [CNT_W-1:0]         err_count_q, err_count_d;

    // Only three distinct expected levels exist: 0 (both stay branches), +AMP, -AMP.
    logic signed [BW-1:0]     ys;
    logic [PM_W-1:0]          bm_zero, bm_pos, bm_neg, bm_min, pm_min;
    logic [1:0][PM_W-1:0]     bm_from0, bm_from1;
    logic                     win;

    always_comb begin
        ys       = {{2{bus.in_sample[SAMPLE_W-1]}}, bus.in_sample};
        bm_zero  = sat_bm(mag(ys));
        bm_pos   = sat_bm(mag(ys - AMP_S));
        bm_neg   = sat_bm(mag(ys + AMP_S));
        bm_from0 = {bm_pos, bm_zero};
        bm_from1 = {bm_zero, bm_neg};
        bm_min   = bm_zero;
        if (bm_pos < bm_min) bm_min = bm_pos;
        if (bm_neg < bm_min) bm_min = bm_neg;
    end

    for (genvar n = 0; n < 2; n++) begin : g_acs
        prml_viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm_a   (pm_q[0]),
            .pm_b   (pm_q[1]),
            .bm_a   (bm_from0[n]),
            .bm_b   (bm_from1[n]),
            .pm_new (pm_acs[n]),
            .sel    (sel[n])
        );
    end

    always_comb begin
        pm_d        = pm_q;
        surv_d      = surv_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        pm_min      = (pm_acs[1] < pm_acs[0]) ? pm_acs[1] : pm_acs[0];
        win         = (pm_acs[1] < pm_acs[0]);
        if (bus.in_valid) begin
            for (int n = 0; n < 2; n++) begin
                pm_d[n]   = pm_acs[n] - pm_min;
                surv_d[n] = {surv_q[sel[n]][TB_DEPTH-2:0], n[0]};
            end
            out_bit_d   = surv_d[win][TB_DEPTH-1];
            out_valid_d = (fill_q == FILL_MAX);
            if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
            err_d = (32'(bm_min) > 32'(ERR_THRESH));
            if (err_d && err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pm_q        <= {{PM_W{1'b1}}, {PM_W{1'b0}}};
            surv_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            pm_q        <= pm_d;
            surv_q      <= surv_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_prml_viterbi_dicode.sv
// Directed + randomized bench for prml_viterbi_dicode; reference is a
// traceback Viterbi over integer metrics kept alongside the stimulus.
module tb_prml_viterbi_dicode;
    localparam int AMP = 32, PMAX = 1023, TBD = 16, THR = 24, CMAX = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    prml_viterbi_dicode_if #(.SAMPLE_W(8), .CNT_W(4)) bus ();
    prml_viterbi_dicode #(.SAMPLE_W(8), .AMP(AMP), .PM_W(10), .TB_DEPTH(TBD),
                          .ERR_THRESH(THR), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, failures = 0;

    // reference model state
    int       pm[2];
    bit [1:0] decs[$];
    int       nacc, ev, eb, ee, ecnt;
    bit       dq[$];
    bit       tx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int bm(input int y, input int e);
        int d = (y > e) ? y - e : e - y;
        return (d > PMAX) ? PMAX : d;
    endfunction

    function automatic int clamp(input int y);
        return (y > 127) ? 127 : (y < -128) ? -128 : y;
    endfunction

    function automatic void model_reset();
        pm[0] = 0; pm[1] = PMAX; decs.delete();
        nacc = 0; ev = 0; eb = 0; ee = 0; ecnt = 0;
    endfunction

    function automatic void model_accept(input int y);
        int np[2]; bit [1:0] d; int mn, minbm, s;
        minbm = PMAX;
        for (int n = 0; n < 2; n++) begin
            int c0, c1;
            c0 = pm[0] + bm(y, AMP * n);        if (c0 > PMAX) c0 = PMAX;
            c1 = pm[1] + bm(y, AMP * (n - 1));  if (c1 > PMAX) c1 = PMAX;
            d[n]  = (c1 < c0);
            np[n] = (c1 < c0) ? c1 : c0;
            for (int p = 0; p < 2; p++)
                if (bm(y, AMP * (n - p)) < minbm) minbm = bm(y, AMP * (n - p));
        end
        mn = (np[0] < np[1]) ? np[0] : np[1];
        pm[0] = np[0] - mn; pm[1] = np[1] - mn;
        decs.push_back(d);
        ev = (nacc >= TBD - 1);
        if (ev) begin
            s = (pm[1] < pm[0]) ? 1 : 0;
            for (int j = 0; j < TBD - 1; j++) s = decs[decs.size() - 1 - j][s];
            eb = s;
        end else eb = 0;
        nacc++;
        ee = (minbm > THR);
        if (ee && ecnt < CMAX) ecnt++;
    endfunction

    task automatic step(input bit v, input int y);
        bus.in_valid  = v;
        bus.in_sample = 8'(clamp(y));
        @(posedge clock); #1;
        if (v) model_accept(clamp(y));
        else begin ev = 0; ee = 0; end
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("out_bit",   32'(bus.out_bit),   32'(eb));
        chk("err",       32'(bus.err),       32'(ee));
        chk("err_count", 32'(bus.err_count), 32'(ecnt));
        if (bus.out_valid) dq.push_back(bus.out_bit);
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_sample = 8'sd100;
        repeat (2) begin
            @(posedge clock); #1;
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_out_bit",   32'(bus.out_bit),   0);
            chk("rst_err",       32'(bus.err),       0);
            chk("rst_err_count", 32'(bus.err_count), 0);
        end
        reset = 1'b0; bus.in_valid = 1'b0;
        model_reset(); dq.delete(); tx.delete();
    endtask

    // Drive tx[] as ideal dicode samples plus alternating +/-noise; bad_idx gets +100.
    task automatic send_tx(input int noise, input int bad_idx, input bit gaps);
        int prev = 0, y;
        for (int i = 0; i < tx.size(); i++) begin
            if (gaps) for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++)
                step(1'b0, int'($urandom_range(255)) - 128);
            y = AMP * (int'(tx[i]) - prev) + ((i % 2 == 0) ? noise : -noise);
            if (i == bad_idx) y = 100;
            step(1'b1, y);
            prev = tx[i];
        end
    endtask

    task automatic cmp_tx(input string tag, input int lo_excl, input int hi_excl);
        chk({tag, "_count"}, 32'(dq.size()), 32'(tx.size() - (TBD - 1)));
        for (int i = 0; i < dq.size(); i++)
            if (i <= lo_excl || i >= hi_excl) chk(tag, 32'(dq[i]), 32'(tx[i]));
    endtask

    function automatic void load_pattern();
        bit [7:0] pat;
        pat = 8'b1001_0110;               // bits 0,1,1,0,1,0,0,1 (LSB first)
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(pat[i]);
        for (int i = 0; i < TBD; i++) tx.push_back(1'b0);
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.in_sample = '0;
        do_reset();

        // 1) noiseless
        load_pattern(); send_tx(0, -1, 1'b0); cmp_tx("t1_bits", -1, 0);
        chk("t1_err_count", 32'(bus.err_count), 0);

        // 2) alternating +/-10 noise
        do_reset(); load_pattern(); send_tx(10, -1, 1'b0); cmp_tx("t2_bits", -1, 0);
        chk("t2_err_count", 32'(bus.err_count), 0);

        // 3) single bad sample mid-stream
        do_reset();
        for (int i = 0; i < 40; i++) tx.push_back(1'($urandom_range(1, 0)));
        for (int i = 0; i < TBD; i++) tx.push_back(1'b0);
        send_tx(0, 20, 1'b0); cmp_tx("t3_bits", 20 - TBD + 1, 20 + TBD - 1);
        chk("t3_err_count", 32'(bus.err_count), 1);

        // 4) random in_valid gaps
        do_reset(); load_pattern(); send_tx(0, -1, 1'b1); cmp_tx("t4_bits", -1, 0);

        // 5) reset mid-stream then the test-1 stream
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, int'($urandom_range(255)) - 128);
        do_reset(); load_pattern(); send_tx(0, -1, 1'b0); cmp_tx("t5_bits", -1, 0);
        chk("t5_err_count", 32'(bus.err_count), 0);

        // 6) random bits, ~sigma 6 noise, rail samples injected; count saturates
        do_reset();
        begin
            int prev = 0, y, a;
            for (int i = 0; i < 2000; i++) begin
                a = int'($urandom_range(1, 0));
                y = AMP * (a - prev) + int'($urandom_range(12)) + int'($urandom_range(12))
                    + int'($urandom_range(12)) - 18;
                if (i % 50 == 25) y = (i % 100 == 25) ? 127 : -128;
                if ($urandom_range(3) == 0) step(1'b0, 0);
                step(1'b1, y);
                prev = a;
            end
        end
        chk("t6_err_count_sat", 32'(bus.err_count), CMAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
